// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the stall/flush sequencer and the pipe units that consume its controls.
package pipeline_hazard_controller_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } hz_state_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detector.sv
// Combinational load-use compare between an execute-stage load and the decode source registers.
module load_use_detector #(
    parameter int REG_INDEX_BITS = 5
) (
    input  logic [REG_INDEX_BITS-1:0] i_rs1_decode,
    input  logic [REG_INDEX_BITS-1:0] i_rs2_decode,
    input  logic                      i_rs1_used_decode,
    input  logic                      i_rs2_used_decode,
    input  logic [REG_INDEX_BITS-1:0] i_rd_execute,
    input  logic                      i_mem_read_execute,
    output logic                      o_hazard
);

    logic w_rs1_match;
    logic w_rs2_match;

    assign w_rs1_match = i_rs1_used_decode && (i_rs1_decode == i_rd_execute);
    assign w_rs2_match = i_rs2_used_decode && (i_rs2_decode == i_rd_execute);

    // x0 is never a real destination, so a load into it cannot create a dependency.
    assign o_hazard = i_mem_read_execute && (i_rd_execute != '0) && (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: prioritises memory freeze, branch redirect, load-use stall and jump redirect.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int ADDRESS_BITS   = 20,
    parameter int REG_INDEX_BITS = 5,
    parameter int FLUSH_CYCLES   = 1,
    parameter int COUNT_BITS     = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [REG_INDEX_BITS-1:0] i_rs1_decode,
    input  logic [REG_INDEX_BITS-1:0] i_rs2_decode,
    input  logic                      i_rs1_used_decode,
    input  logic                      i_rs2_used_decode,
    input  logic [REG_INDEX_BITS-1:0] i_rd_execute,
    input  logic                      i_mem_read_execute,
    input  logic                      i_branch_taken_execute,
    input  logic [ADDRESS_BITS-1:0]   i_branch_target_execute,
    input  logic                      i_jump_decode,
    input  logic [ADDRESS_BITS-1:0]   i_jump_target_decode,
    input  logic                      i_dmem_ready,
    output logic                      o_stall_fetch,
    output logic                      o_stall_decode,
    output logic                      o_flush_decode,
    output logic                      o_bubble_execute,
    output logic [1:0]                o_pc_select,
    output logic [ADDRESS_BITS-1:0]   o_pc_target,
    output logic [COUNT_BITS-1:0]     o_stall_cycles
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    hz_state_t             r_state;
    hz_state_t             w_state_next;
    logic [2:0]            r_flush_cnt;
    logic [2:0]            w_flush_cnt_next;
    logic [COUNT_BITS-1:0] r_stall_cycles;

    logic       w_hazard;
    logic       w_stall;
    logic       w_flush;
    logic       w_bubble;
    logic [1:0] w_pc_select;

    load_use_detector #(
        .REG_INDEX_BITS (REG_INDEX_BITS)
    ) u_load_use_detector (
        .i_rs1_decode       (i_rs1_decode),
        .i_rs2_decode       (i_rs2_decode),
        .i_rs1_used_decode  (i_rs1_used_decode),
        .i_rs2_used_decode  (i_rs2_used_decode),
        .i_rd_execute       (i_rd_execute),
        .i_mem_read_execute (i_mem_read_execute),
        .o_hazard           (w_hazard)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_RUN;
            r_flush_cnt    <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_stall          = 1'b0;
        w_flush          = 1'b0;
        w_bubble         = 1'b0;
        w_pc_select      = PC_PLUS4;

        if (!i_dmem_ready) begin
            w_stall      = 1'b1;
            w_state_next = ST_MEM_WAIT;
        end else if (i_branch_taken_execute) begin
            w_pc_select      = PC_BRANCH;
            w_flush          = 1'b1;
            w_bubble         = 1'b1;
            w_state_next     = ST_FLUSH;
            w_flush_cnt_next = FLUSH_LOAD;
        end else if (w_hazard && (r_state == ST_RUN || r_state == ST_MEM_WAIT)) begin
            // MEM_WAIT resolves like RUN on the cycle memory becomes ready.
            w_stall      = 1'b1;
            w_bubble     = 1'b1;
            w_state_next = ST_LOAD_STALL;
        end else if (i_jump_decode && (r_state != ST_FLUSH)) begin
            w_pc_select      = PC_JUMP;
            w_state_next     = ST_FLUSH;
            w_flush_cnt_next = FLUSH_LOAD;
        end else if (r_state == ST_FLUSH) begin
            w_flush = 1'b1;
            if (r_flush_cnt <= 3'd1) begin
                w_state_next     = ST_RUN;
                w_flush_cnt_next = '0;
            end else begin
                w_flush_cnt_next = r_flush_cnt - 3'd1;
            end
        end else begin
            w_state_next = ST_RUN;
        end
    end

    assign o_stall_fetch    = w_stall;
    assign o_stall_decode   = w_stall;
    assign o_flush_decode   = w_flush;
    assign o_bubble_execute = w_bubble;
    assign o_pc_select      = w_pc_select;
    assign o_pc_target      = (w_pc_select == PC_BRANCH) ? i_branch_target_execute :
                              (w_pc_select == PC_JUMP)   ? i_jump_target_decode    : '0;
    assign o_stall_cycles   = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed vector bench for the stall/flush sequencer, with flush-length and counter-width variants.
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, bt, jd, rdy;
    logic [19:0] btgt, jtgt;

    logic        m_stf, m_std, m_fl, m_bu;
    logic [1:0]  m_sel;
    logic [19:0] m_tgt;
    logic [15:0] m_cnt;

    logic        t_stf, t_std, t_fl, t_bu;
    logic [1:0]  t_sel;
    logic [19:0] t_tgt;
    logic [15:0] t_cnt;

    logic        s_stf, s_std, s_fl, s_bu;
    logic [1:0]  s_sel;
    logic [19:0] s_tgt;
    logic [3:0]  s_cnt;

    pipeline_hazard_controller #(.FLUSH_CYCLES(1), .COUNT_BITS(16)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_rs1_decode(rs1), .i_rs2_decode(rs2),
        .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
        .i_rd_execute(rd), .i_mem_read_execute(mr),
        .i_branch_taken_execute(bt), .i_branch_target_execute(btgt),
        .i_jump_decode(jd), .i_jump_target_decode(jtgt), .i_dmem_ready(rdy),
        .o_stall_fetch(m_stf), .o_stall_decode(m_std), .o_flush_decode(m_fl),
        .o_bubble_execute(m_bu), .o_pc_select(m_sel), .o_pc_target(m_tgt),
        .o_stall_cycles(m_cnt));

    pipeline_hazard_controller #(.FLUSH_CYCLES(3), .COUNT_BITS(16)) dut_f3 (
        .i_clock(clk), .i_reset(rst_n),
        .i_rs1_decode(rs1), .i_rs2_decode(rs2),
        .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
        .i_rd_execute(rd), .i_mem_read_execute(mr),
        .i_branch_taken_execute(bt), .i_branch_target_execute(btgt),
        .i_jump_decode(jd), .i_jump_target_decode(jtgt), .i_dmem_ready(rdy),
        .o_stall_fetch(t_stf), .o_stall_decode(t_std), .o_flush_decode(t_fl),
        .o_bubble_execute(t_bu), .o_pc_select(t_sel), .o_pc_target(t_tgt),
        .o_stall_cycles(t_cnt));

    pipeline_hazard_controller #(.FLUSH_CYCLES(1), .COUNT_BITS(4)) dut_c4 (
        .i_clock(clk), .i_reset(rst_n),
        .i_rs1_decode(rs1), .i_rs2_decode(rs2),
        .i_rs1_used_decode(u1), .i_rs2_used_decode(u2),
        .i_rd_execute(rd), .i_mem_read_execute(mr),
        .i_branch_taken_execute(bt), .i_branch_target_execute(btgt),
        .i_jump_decode(jd), .i_jump_target_decode(jtgt), .i_dmem_ready(rdy),
        .o_stall_fetch(s_stf), .o_stall_decode(s_std), .o_flush_decode(s_fl),
        .o_bubble_execute(s_bu), .o_pc_select(s_sel), .o_pc_target(s_tgt),
        .o_stall_cycles(s_cnt));

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, mr, bt, jd, rdy;
        logic [19:0] btgt, jtgt;
        logic        e_st, e_fl, e_bu;
        logic [1:0]  e_sel;
        logic [19:0] e_tgt;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input int a_rs1, input int a_rs2, input int a_u1, input int a_u2,
                       input int a_rd, input int a_mr, input int a_bt, input int a_btgt,
                       input int a_jd, input int a_jtgt, input int a_rdy,
                       input int x_st, input int x_fl, input int x_bu, input int x_sel,
                       input int x_tgt);
        vec_t v;
        v.rs1 = 5'(a_rs1);  v.rs2 = 5'(a_rs2);  v.u1 = 1'(a_u1);  v.u2 = 1'(a_u2);
        v.rd  = 5'(a_rd);   v.mr  = 1'(a_mr);   v.bt = 1'(a_bt);  v.btgt = 20'(a_btgt);
        v.jd  = 1'(a_jd);   v.jtgt = 20'(a_jtgt); v.rdy = 1'(a_rdy);
        v.e_st = 1'(x_st);  v.e_fl = 1'(x_fl);  v.e_bu = 1'(x_bu);
        v.e_sel = 2'(x_sel); v.e_tgt = 20'(x_tgt);
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0; mr = 0;
        bt = 0; btgt = 0; jd = 0; jtgt = 0; rdy = 1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inputs: rs1 rs2 u1 u2 rd mr bt btgt jd jtgt rdy | stall flush bubble sel tgt
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(5,0,1,0,5,1,0,0,0,0,1,       1,0,1,0,0);
        add(5,0,1,0,5,1,0,0,0,0,1,       0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(0,0,1,0,0,1,0,0,0,0,1,       0,0,0,0,0);
        add(0,7,0,1,7,1,0,0,0,0,1,       1,0,1,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(0,7,0,0,7,1,0,0,0,0,1,       0,0,0,0,0);
        add(5,0,1,0,5,1,1,'h100,1,'h40,1, 0,1,1,1,'h100);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,1,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,1,'h40,1,    0,0,0,2,'h40);
        add(0,0,0,0,0,0,0,0,1,'h40,1,    0,1,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(5,0,1,0,5,1,0,0,0,0,0,       1,0,0,0,0);
        add(5,0,1,0,5,1,0,0,0,0,0,       1,0,0,0,0);
        add(5,0,1,0,5,1,0,0,0,0,0,       1,0,0,0,0);
        add(5,0,1,0,5,1,0,0,0,0,1,       1,0,1,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(0,0,0,0,0,0,0,0,1,'h40,1,    0,0,0,2,'h40);
        add(0,0,0,0,0,0,1,'h200,0,0,1,   0,1,1,1,'h200);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,1,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(5,0,1,0,5,1,0,0,0,0,1,       1,0,1,0,0);
        add(5,0,1,0,5,1,0,0,1,'h40,1,    0,0,0,2,'h40);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,1,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);
        add(0,0,0,0,0,0,1,'h300,0,0,0,   1,0,0,0,0);
        add(0,0,0,0,0,0,1,'h300,0,0,1,   0,1,1,1,'h300);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,1,0,0,0);
        add(0,0,0,0,0,0,0,0,0,0,1,       0,0,0,0,0);

        idle();
        rst_n = 1'b0;
        #3;
        chk("reset_stall", m_stf, 0);
        chk("reset_flush", m_fl, 0);
        chk("reset_bubble", m_bu, 0);
        chk("reset_sel", m_sel, 0);
        chk("reset_tgt", m_tgt, 0);
        chk("reset_cnt", m_cnt, 0);
        #9 rst_n = 1'b1;
        step();

        for (int i = 0; i < vq.size(); i++) begin
            rs1 = vq[i].rs1; rs2 = vq[i].rs2; u1 = vq[i].u1; u2 = vq[i].u2;
            rd = vq[i].rd; mr = vq[i].mr; bt = vq[i].bt; btgt = vq[i].btgt;
            jd = vq[i].jd; jtgt = vq[i].jtgt; rdy = vq[i].rdy;
            #3;
            chk($sformatf("v%0d_stall_fetch", i), m_stf, vq[i].e_st);
            chk($sformatf("v%0d_stall_decode", i), m_std, vq[i].e_st);
            chk($sformatf("v%0d_flush", i), m_fl, vq[i].e_fl);
            chk($sformatf("v%0d_bubble", i), m_bu, vq[i].e_bu);
            chk($sformatf("v%0d_pc_select", i), m_sel, vq[i].e_sel);
            chk($sformatf("v%0d_pc_target", i), m_tgt, vq[i].e_tgt);
            chk($sformatf("v%0d_stall_cycles", i), m_cnt, exp_cnt);
            step();
            if (vq[i].e_st) exp_cnt++;
        end
        chk("table_end_stall_cycles", m_cnt, exp_cnt);

        // Asynchronous reset in the middle of a flush window.
        idle();
        bt = 1; btgt = 20'h00100;
        #3;
        chk("rst_branch_sel", m_sel, 1);
        step();
        idle();
        #2;
        chk("rst_pre_flush", m_fl, 1);
        chk("rst_pre_flush_f3", t_fl, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_flush", m_fl, 0);
        chk("rst_async_flush_f3", t_fl, 0);
        chk("rst_async_cnt", m_cnt, 0);
        chk("rst_async_stall", m_stf, 0);
        chk("rst_async_sel", m_sel, 0);
        step();
        rst_n = 1'b1;
        #3;
        chk("rst_after_flush", m_fl, 0);
        chk("rst_after_flush_f3", t_fl, 0);
        step();

        // Jump redirect: main instance flushes 1 cycle, FLUSH_CYCLES=3 instance flushes 3.
        jd = 1; jtgt = 20'h00040;
        #3;
        chk("jump_sel", m_sel, 2);
        chk("jump_tgt", m_tgt, 'h40);
        chk("jump_flush", m_fl, 0);
        chk("jump_sel_f3", t_sel, 2);
        chk("jump_tgt_f3", t_tgt, 'h40);
        chk("jump_flush_f3", t_fl, 0);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            #3;
            chk($sformatf("jump_f3_flush_%0d", k), t_fl, 1);
            chk($sformatf("jump_f3_sel_%0d", k), t_sel, 0);
            chk($sformatf("jump_f1_flush_%0d", k), m_fl, (k == 0) ? 1 : 0);
            step();
        end
        #3;
        chk("jump_f3_done", t_fl, 0);
        step();

        // Saturation: 20 freeze cycles from a cleared counter.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("sat_start", s_cnt, 0);
        rdy = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("sat_c4_%0d", k), s_cnt, (k > 15) ? 15 : k);
            chk($sformatf("sat_c16_%0d", k), m_cnt, k);
        end
        rdy = 1;
        #3;
        chk("sat_release_stall", s_stf, 0);
        step();
        chk("sat_hold", s_cnt, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the 5-stage stall-bypass core. Watches decode source registers, the execute-stage load, execute-stage branch resolution, decode-stage jumps and data-memory readiness. Drives the fetch/decode pipe-register `stall`, decode-slot NOP replacement, execute bubble insertion and next-PC selection. Sits beside the fetch, decode and execute pipe units and is their only source of `stall`/flush control.

## Interface
- `ADDRESS_BITS`, 20, PC width
- `REG_INDEX_BITS`, 5, register index width
- `FLUSH_CYCLES`, 1, extra cycles decode is squashed after a redirect (1..7)
- `COUNT_BITS`, 16, width of the stall-cycle counter
- `clock` in 1: sole clock; all state changes on rising edge
- `reset` in 1: asynchronous, active-low; one clock; reset is asynchronous and active-low
- `rs1_decode`, `rs2_decode` in REG_INDEX_BITS: decode source registers
- `rs1_used_decode`, `rs2_used_decode` in 1: source actually read
- `rd_execute` in REG_INDEX_BITS: execute destination
- `mem_read_execute` in 1: execute instruction is a load
- `branch_taken_execute` in 1: branch resolved taken in execute
- `branch_target_execute` in ADDRESS_BITS: its target
- `jump_decode` in 1: JAL decoded
- `jump_target_decode` in ADDRESS_BITS: its target
- `dmem_ready` in 1: data memory can complete this cycle
- `stall_fetch`, `stall_decode` out 1: hold PC / fetch-decode register
- `flush_decode` out 1: replace decode instruction with NOP (0x00000013)
- `bubble_execute` out 1: insert NOP into decode-execute register
- `pc_select` out 2: 0 = PC+4, 1 = branch target, 2 = jump target
- `pc_target` out ADDRESS_BITS: selected redirect target, 0 when `pc_select`=0
- `stall_cycles` out COUNT_BITS: saturating count of cycles with `stall_fetch`=1

## Operation
- FSM states: RUN, LOAD_STALL, FLUSH, MEM_WAIT. The flush counter is 3 bits.
- Load-use hazard: `mem_read_execute` && `rd_execute`≠0 && ((`rs1_used_decode` && `rs1_decode`==`rd_execute`) || (rs2 likewise)).
- Priority each cycle, highest first:
  1. `dmem_ready`=0: freeze. `stall_fetch`=`stall_decode`=1, no bubble, no flush, `pc_select`=0. Next state is MEM_WAIT.
  2. `branch_taken_execute`: `pc_select`=1, `flush_decode`=1, `bubble_execute`=1. Next state is FLUSH with the counter loaded with FLUSH_CYCLES. Overrides load-use and jump.
  3. Load-use hazard while in RUN: `stall_fetch`=`stall_decode`=1, `bubble_execute`=1. Next state is LOAD_STALL.
  4. `jump_decode` while in RUN or LOAD_STALL: `pc_select`=2, `flush_decode`=0 this cycle. Next state is FLUSH with the counter set to FLUSH_CYCLES.
  5. Otherwise all controls are 0.
- LOAD_STALL: hazard detection is masked; the load has moved to memory. Returns to RUN unless rule 1, 2 or 4 fires.
- FLUSH: `flush_decode`=1, counter decrements, returns to RUN when counter reaches 1. A taken branch in FLUSH reloads the counter.
- MEM_WAIT: leaves to RUN on the first `dmem_ready`=1 cycle, and rules 2–4 are evaluated in that same cycle. A redirect that is pending when the freeze begins stays valid because the upstream registers are held.
- `stall_cycles` increments when `stall_fetch`=1 and saturates at all-ones. It never wraps.
- All outputs except `stall_cycles` are combinational from current state and inputs. State and counters are registered.

## Timing
- Reset (`reset`=0, asynchronous): state RUN, flush counter 0, `stall_cycles` 0. With idle inputs all control outputs are 0 and `pc_target` is 0.
- Load-use adds exactly 1 stall cycle. The dependent instruction reaches execute 2 cycles after the hazard is first seen.
- A taken branch squashes the decode slot in the redirect cycle plus FLUSH_CYCLES following cycles. The target instruction reaches decode after FLUSH_CYCLES+1 cycles.
- A jump squashes FLUSH_CYCLES cycles starting the cycle after the redirect.
- Reset asserted mid-FLUSH or mid-MEM_WAIT returns to RUN immediately. The counter clears without waiting for a clock edge.

## Structure
- The shared core package holds: the NOP constant 32'h00000013, the state enum (2 bits), and the `pc_select` encodings PC_PLUS4, PC_BRANCH, PC_JUMP.
- One sub-module, `load_use_detector`: purely combinational hazard compare, reused by the forwarding unit.

## Test plan
- **Reset.** Assert `reset`=0 mid-FLUSH → state RUN, `stall_cycles`=0, all controls 0 before the next edge.
- **Load-use.** Load x5 in execute, decode reads rs1=x5 → one cycle of stall+bubble, then RUN. `stall_cycles`=1. The same case with `rd_execute`=x0 → no stall.
- **Branch during load-use.** `branch_taken_execute` with target 0x00100 in the same cycle as a load-use hazard → `pc_select`=1, `pc_target`=0x00100, flush+bubble, no stall. `flush_decode` stays high for FLUSH_CYCLES more cycles.
- **Memory wait.** `dmem_ready` held 0 for 3 cycles with a load-use hazard present → 3 freeze cycles with no bubble. The next cycle takes the load-use stall. `stall_cycles`=4.
- **Jump.** `jump_decode` with target 0x00040 → `pc_select`=2 for one cycle, then `flush_decode`=1 for FLUSH_CYCLES cycles. Repeat with FLUSH_CYCLES=3.
- **Saturation.** COUNT_BITS=4 with 20 freeze cycles → `stall_cycles` holds at 15.
